// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Multi-cycle sequencer between the MEM pipeline stage and a word-addressed
//   data memory. It latches one load/store request, drives the memory port for
//   WAIT_CYCLES cycles, and then returns the result. While an access is in
//   flight, ready is held low so that the pipeline freezes.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   wr_req, rd_req   store / load request levels (wr_req wins when both set)
//   addr, wdata      CPU byte address (bits[1:0] ignored) and store data
//   ready            1 = idle with no request, or access completing this cycle
//   rdata            registered load result, valid in DONE
//   addr_err         registered, 1 in DONE when the latched address was out of range
//   mem_w_en         memory write enable, single-cycle pulse at the end of a store
//   mem_r_en         memory read enable, high for every ACCESS cycle of a load
//   mem_addr         memory byte offset (addr - ADDR_BASE, word aligned)
//   mem_wdata        memory write data
//   mem_rdata        combinational read data from memory
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int unsigned DEPTH_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        mem_w_en,
  output logic        mem_r_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] ADDR_END = ADDR_BASE + 32'(4 * DEPTH_WORDS);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        op_wr;
  logic        in_range;
  logic [31:0] off_q;
  logic [31:0] wdata_q;

  logic        req;
  logic [31:0] addr_al;
  logic [31:0] req_off;
  logic        req_ok;

  assign req     = wr_req | rd_req;
  assign addr_al = {addr[31:2], 2'b00};
  assign req_off = addr_al - ADDR_BASE;
  assign req_ok  = (addr_al >= ADDR_BASE) && (addr_al < ADDR_END);

  // The offset and range verdict are computed from the incoming address and
  // registered at latch time. This is equivalent to checking the latched
  // address afterwards, and it keeps mem_addr at 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_wr    <= 1'b0;
      in_range <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            op_wr    <= wr_req;
            off_q    <= req_off;
            wdata_q  <= wdata;
            in_range <= req_ok;
            cnt      <= CNT_INIT;
            addr_err <= 1'b0;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt == 4'd0) begin
            rdata    <= (!op_wr && in_range) ? mem_rdata : '0;
            addr_err <= ~in_range;
            state    <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready = 1'b0;
    case (state)
      S_IDLE:  ready = ~req;
      S_DONE:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign mem_r_en  = (state == S_ACCESS) && in_range && !op_wr;
  assign mem_w_en  = (state == S_ACCESS) && in_range && op_wr && (cnt == 4'd0);
  assign mem_addr  = off_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. A simple word memory is attached to the memory
// port. An independent transaction-level reference (address range rule, word
// array, expected latency and enable counts) predicts each access outcome.
module tb_mem_access_ctrl;

  localparam int unsigned W     = 4;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req, rd_req;
  logic [31:0] addr, wdata;
  logic        ready, addr_err, mem_w_en, mem_r_en;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tbmem   [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.WAIT_CYCLES(W), .ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .addr(addr),
    .wdata(wdata), .ready(ready), .rdata(rdata), .addr_err(addr_err),
    .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = (mem_addr < 32'(4 * DEPTH)) ? tbmem[mem_addr[6:2]] : 32'hBAD0_BAD0;

  always @(posedge clk)
    if (mem_w_en && mem_addr < 32'(4 * DEPTH)) tbmem[mem_addr[6:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request, assumed to start in an IDLE cycle just after a clock
  // edge. It leaves the request asserted, so the caller chooses back-to-back or idle.
  task automatic xact(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] al, off, exp_rd;
    logic        ok;
    int          freeze, rcnt, wcnt;
    bit          done;
    al  = a & 32'hFFFF_FFFC;
    ok  = (al >= BASE) && (al < BASE + 4 * DEPTH);
    off = al - BASE;
    wr_req = w; rd_req = r; addr = a; wdata = d;
    freeze = 0; rcnt = 0; wcnt = 0; done = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ready) begin
        done = 1;
        break;
      end
      freeze++;
      if (mem_r_en) rcnt++;
      if (mem_w_en) begin
        wcnt++;
        check("mem_wdata", mem_wdata, d);
      end
      if (mem_r_en || mem_w_en) check("mem_addr", mem_addr, off);
    end
    check("done_reached", 32'(done), 32'd1);
    if (w && ok) ref_mem[off[6:2]] = d;
    exp_rd = (!w && ok) ? ref_mem[off[6:2]] : 32'd0;
    check("freeze_cycles", 32'(freeze), 32'(W + 1));
    check("r_en_cycles", 32'(rcnt), (!w && ok) ? 32'(W) : 32'd0);
    check("w_en_pulses", 32'(wcnt), (w && ok) ? 32'd1 : 32'd0);
    check("rdata", rdata, exp_rd);
    check("addr_err", 32'(addr_err), ok ? 32'd0 : 32'd1);
    check("done_enables", {30'd0, mem_r_en, mem_w_en}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wr_req = 1'b0; rd_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic reset_mid(input logic w, input logic [31:0] a, input logic [31:0] d);
    wr_req = w; rd_req = ~w; addr = a; wdata = d;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rdata", rdata, 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_enables", {30'd0, mem_r_en, mem_w_en}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      tbmem[i] = '0;
      ref_mem[i] = '0;
    end
    rst = 1'b1; wr_req = 0; rd_req = 0; addr = '0; wdata = '0;
    #1;
    check("por_ready", 32'(ready), 32'd1);
    check("por_rdata", rdata, 32'd0);
    check("por_addr_err", 32'(addr_err), 32'd0);
    check("por_mem_addr", mem_addr, 32'd0);
    check("por_enables", {30'd0, mem_r_en, mem_w_en}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    xact(1, 0, 1028, 32'hDEADBEEF); idle();
    xact(0, 1, 1028, 32'h0);         idle();
    xact(1, 0, 1032, 32'h11111111); idle();
    reset_mid(0, 1028, 32'h0);
    reset_mid(1, 1032, 32'h22222222);
    xact(0, 1, 1032, 32'h0);         idle();
    xact(0, 1, 1020, 32'h0);         idle();
    xact(1, 0, 1152, 32'h12345678); idle();
    xact(1, 1, 1032, 32'd5);         idle();
    xact(0, 1, 1032, 32'h0);         idle();
    xact(0, 1, 1024, 32'h0);
    xact(0, 1, 1028, 32'h0);         idle();

    for (int n = 0; n < 40; n++) begin
      logic        rw;
      logic [31:0] ra;
      rw = 1'($urandom_range(0, 1));
      ra = BASE - 16 + $urandom_range(0, 4 * DEPTH + 31);
      xact(rw, rw ? 1'($urandom_range(0, 1)) : 1'b1, ra, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
